// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming KxK sliding-window generator.
// Accepts raster-order pixels, keeps K-1 previous rows in column-addressed
// line buffers, and emits every legal KxK window (flattened, r=0 oldest row,
// c=0 leftmost column) one cycle after the pixel that completes it.
// Optional feature macro: CONV_WIN_COORD_EN adds win_row/win_col outputs
// carrying the top-left coordinate of the window on win_out.
module conv_window_gen #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 36,
    parameter int unsigned K      = 3,
    parameter int unsigned STRIDE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     valid_out,
    output logic [K*K*DATA_W-1:0]    win_out,
    output logic                     frame_done
`ifdef CONV_WIN_COORD_EN
    ,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col
`endif
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
    localparam logic [RW-1:0] ROW_PRE   = RW'(K - 2);

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Line buffer 0 holds the oldest row, buffer K-2 the row just above data_in.
    logic [DATA_W-1:0] lb [K-1][IMG_W];

    logic [K*K*DATA_W-1:0] win_q;
    logic [K*K*DATA_W-1:0] win_d;

    logic col_wrap;
    logic frame_wrap;
    logic phase_ok;
    logic legal;

    // Position decode and window-legality for the pixel being accepted.
    always_comb begin
        col_wrap   = (col == COL_LAST);
        frame_wrap = col_wrap && (row == ROW_LAST);
        // Stride 2: (x-(K-1)) is even exactly when bit 0 of x matches bit 0 of K-1.
        if (STRIDE == 1) begin
            phase_ok = 1'b1;
        end else begin
            phase_ok = (col[0] == COL_FIRST[0]) && (row[0] == ROW_FIRST[0]);
        end
        legal = valid_in && (state_q == RUN) && (col >= COL_FIRST) && phase_ok;
    end

    // Next window: shift left one column, new right column from line buffers + data_in.
    always_comb begin
        win_d = win_q;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c + 1 < K; c++) begin
                win_d[(r*K+c)*DATA_W +: DATA_W] = win_q[(r*K+c+1)*DATA_W +: DATA_W];
            end
        end
        for (int unsigned r = 0; r + 1 < K; r++) begin
            win_d[(r*K+K-1)*DATA_W +: DATA_W] = lb[r][col];
        end
        win_d[(K*K-1)*DATA_W +: DATA_W] = data_in;
    end

    // FSM next state: RUN once the K-1 buffered rows are full, FILL again at frame wrap.
    always_comb begin
        state_d = state_q;
        if (valid_in) begin
            if (frame_wrap) begin
                state_d = FILL;
            end else if (col_wrap && (row == ROW_PRE)) begin
                state_d = RUN;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Raster position counters, advancing only on accepted pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (col_wrap) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Line buffers and working window; contents need no reset because
    // legality gating keeps stale data from reaching win_out.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            win_q <= win_d;
            for (int unsigned r = 0; r + 2 < K; r++) begin
                lb[r][col] <= lb[r+1][col];
            end
            lb[K-2][col] <= data_in;
        end
    end

    // Registered outputs: window, valid strobe, frame-end pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            win_out    <= '0;
        end else begin
            valid_out  <= legal;
            frame_done <= valid_in && frame_wrap;
            if (legal) begin
                win_out <= win_d;
            end
        end
    end

`ifdef CONV_WIN_COORD_EN
    // Top-left coordinate of the emitted window, registered alongside valid_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_row <= '0;
            win_col <= '0;
        end else if (legal) begin
            win_row <= row - ROW_FIRST;
            win_col <= col - COL_FIRST;
        end
    end
`endif

endmodule
